// File: rtl/maze_pkg.sv
// Shared constants, state encoding and helpers for the maze memory arbiter.
package maze_pkg;

  // Requester indices on the shared maze RAM port.
  localparam int REQ_LOAD  = 0;
  localparam int REQ_SOLVE = 1;
  localparam int REQ_SHOW  = 2;
  localparam int NUM_REQ   = 3;

  // Default coordinate width; the RAM address is {Y,X}.
  localparam int COORD_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Round-robin pointer following a one-hot owner: (owner+1) mod 3.
  function automatic logic [1:0] next_rr_ptr(input logic [NUM_REQ-1:0] owner);
    if (owner[REQ_LOAD]) begin
      return 2'd1;
    end else if (owner[REQ_SOLVE]) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/maze_rr_pick.sv
// Combinational winner selection: loader-only while locked, else round-robin
// scan starting at rr_ptr.
module maze_rr_pick
  import maze_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  input  logic               lock_own,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);

  // Priority scan rotated by rr_ptr; the lock overrides everything.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    if (lock_own) begin
      win[REQ_LOAD] = req[REQ_LOAD];
      valid         = req[REQ_LOAD];
    end else begin
      valid = |req;
      case (rr_ptr)
        2'd1: begin
          if (req[1])      win = 3'b010;
          else if (req[2]) win = 3'b100;
          else if (req[0]) win = 3'b001;
        end
        2'd2: begin
          if (req[2])      win = 3'b100;
          else if (req[0]) win = 3'b001;
          else if (req[1]) win = 3'b010;
        end
        default: begin
          if (req[0])      win = 3'b001;
          else if (req[1]) win = 3'b010;
          else if (req[2]) win = 3'b100;
        end
      endcase
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbitrates three single-cell requesters onto the single-port maze RAM.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ*2*COORD_W-1:0]   addr,
  input  logic [NUM_REQ-1:0]             wdata,
  input  logic                           ld_lock,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           rdata,
  output logic                           busy,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [2*COORD_W-1:0]           mem_addr,
  output logic                           mem_wdata,
  input  logic                           mem_rdata
);

  localparam int         AW       = 2 * COORD_W;
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] owner_reg, owner_next;
  logic               we_reg, we_next;
  logic [AW-1:0]      addr_reg, addr_next;
  logic               wdata_reg, wdata_next;
  logic [1:0]         cnt_reg, cnt_next;
  logic               rdata_reg, rdata_next;
  logic [1:0]         rr_ptr_reg, rr_ptr_next;
  logic               lock_own_reg, lock_own_next;

  logic               lock_eff;
  logic [NUM_REQ-1:0] win;
  logic               win_valid;
  logic [AW-1:0]      addr_sel;
  logic               we_sel;
  logic               wdata_sel;

  // The lock lapses once the loader has dropped both ld_lock and its request.
  assign lock_eff = lock_own_reg & (ld_lock | req[REQ_LOAD]);

  maze_rr_pick u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_reg),
    .lock_own (lock_eff),
    .win      (win),
    .valid    (win_valid)
  );

  // Select the winning requester's address slice.
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) addr_sel = addr[i*AW +: AW];
    end
  end

  assign we_sel    = |(win & we);
  assign wdata_sel = |(win & wdata);

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 1'b0;
      cnt_reg      <= '0;
      rdata_reg    <= 1'b0;
      rr_ptr_reg   <= '0;
      lock_own_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      cnt_reg      <= cnt_next;
      rdata_reg    <= rdata_next;
      rr_ptr_reg   <= rr_ptr_next;
      lock_own_reg <= lock_own_next;
    end
  end

  // Next-state logic: latch winner in IDLE, count read latency in WAIT,
  // rotate priority and update the loader lock in RESP.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    rdata_next    = rdata_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_own_next = lock_own_reg;
    case (state_reg)
      IDLE: begin
        if (lock_own_reg && !lock_eff) lock_own_next = 1'b0;
        if (win_valid) begin
          owner_next = win;
          we_next    = we_sel;
          addr_next  = addr_sel;
          wdata_next = wdata_sel;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = RESP;
        end else begin
          cnt_next   = LAT_INIT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1) begin
          rdata_next = mem_rdata;
          state_next = RESP;
        end
      end
      RESP: begin
        rr_ptr_next   = next_rr_ptr(owner_reg);
        lock_own_next = owner_reg[REQ_LOAD] & ld_lock;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign gnt       = busy ? owner_reg : '0;
  assign ack       = (state_reg == RESP) ? owner_reg : '0;
  assign rdata     = (state_reg == RESP) & ~we_reg & rdata_reg;
  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = mem_en & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench: one arbiter with RD_LAT=1 (a) and one with RD_LAT=3 (b),
// each with its own behavioural RAM, sharing the requester stimulus.
module tb_maze_mem_arbiter;

  localparam int AW = 8;

  logic            Clk;
  logic            Rst_n;
  logic [2:0]      req, we, wdata;
  logic [3*AW-1:0] addr;
  logic            ld_lock;

  logic [2:0]      gnt_a, ack_a, gnt_b, ack_b;
  logic            rdata_a, busy_a, mem_en_a, mem_we_a, mem_wdata_a, mem_rdata_a;
  logic            rdata_b, busy_b, mem_en_b, mem_we_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0]   mem_addr_a, mem_addr_b;

  logic            load_en;
  logic [AW-1:0]   load_addr;
  bit              mem_a [256];
  bit              mem_b [256];
  bit   [2:0]      pipe_a, pipe_b;

  int total = 0;
  int bad   = 0;

  maze_mem_arbiter #(.COORD_W(4), .RD_LAT(1)) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ld_lock(ld_lock), .gnt(gnt_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  maze_mem_arbiter #(.COORD_W(4), .RD_LAT(3)) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ld_lock(ld_lock), .gnt(gnt_b), .ack(ack_b), .rdata(rdata_b), .busy(busy_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural RAMs: write on mem_en&mem_we, read data delayed through a pipe.
  always @(posedge Clk) begin
    if (load_en) begin
      mem_a[load_addr] <= 1'b1;
      mem_b[load_addr] <= 1'b1;
    end
    if (mem_en_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
    if (mem_en_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    pipe_a <= {pipe_a[1:0], mem_a[mem_addr_a]};
    pipe_b <= {pipe_b[1:0], mem_b[mem_addr_b]};
  end

  assign mem_rdata_a = pipe_a[0];
  assign mem_rdata_b = pipe_b[2];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic idle(input int n);
    req = 3'b000;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Count cycles until any ack on instance a; g collects every gnt seen.
  task automatic wait_any_ack(input int budget, output int n, output logic [2:0] g);
    n = 0;
    g = gnt_a;
    while (ack_a == 3'b000 && n < budget) begin
      tick();
      n++;
      g |= gnt_a;
    end
  endtask

  int          n;
  logic [2:0]  g;
  logic [2:0]  exp_ack [4];
  logic        exp_rd  [4];

  initial begin
    Rst_n = 1'b0; req = '0; we = '0; wdata = '0; addr = '0; ld_lock = 1'b0;
    load_en = 1'b0; load_addr = '0;
    #3;
    check("rst_gnt",    32'(gnt_a),      0);
    check("rst_busy",   32'(busy_a),     0);
    check("rst_mem_en", 32'(mem_en_a),   0);
    check("rst_addr",   32'(mem_addr_a), 0);
    check("rst_rdata",  32'(rdata_a),    0);
    check("rst_b_busy", 32'(busy_b),     0);

    // Preload cells 0x35 and 0xA5 with 1 in both RAMs.
    load_en = 1'b1; load_addr = 8'h35; tick();
    load_addr = 8'hA5; tick();
    load_en = 1'b0;
    Rst_n = 1'b1;
    tick(); tick();

    // Single solver read of {3,5}.
    req = 3'b010; we = 3'b000; set_addr(1, 8'h35);
    check("rd_c0_busy", 32'(busy_a), 0);
    tick();
    check("rd_c1_en",   32'(mem_en_a),   1);
    check("rd_c1_addr", 32'(mem_addr_a), 32'h35);
    check("rd_c1_we",   32'(mem_we_a),   0);
    check("rd_c1_gnt",  32'(gnt_a),      32'b010);
    tick();
    check("rd_c2_ack",  32'(ack_a),      0);
    tick();
    check("rd_c3_ack",  32'(ack_a),      32'b010);
    check("rd_c3_data", 32'(rdata_a),    1);
    req = 3'b000;
    tick();
    check("rd_c4_gnt",  32'(gnt_a),      0);
    idle(6);

    // Single loader write of 1 to 0xFF.
    req = 3'b001; we = 3'b001; wdata = 3'b001; set_addr(0, 8'hFF);
    tick();
    check("wr_c1_we",    32'(mem_we_a),    1);
    check("wr_c1_addr",  32'(mem_addr_a),  32'hFF);
    check("wr_c1_wdata", 32'(mem_wdata_a), 1);
    tick();
    check("wr_c2_ack",   32'(ack_a),       32'b001);
    check("wr_c2_rdata", 32'(rdata_a),     0);
    idle(6);

    // Solver writes 0 to 0x35.
    req = 3'b010; we = 3'b010; wdata = 3'b000; set_addr(1, 8'h35);
    wait_any_ack(10, n, g);
    check("wr0_lat", 32'(n),     2);
    check("wr0_ack", 32'(ack_a), 32'b010);
    idle(6);

    // Display reads back 0xFF.
    req = 3'b100; we = 3'b000; set_addr(2, 8'hFF);
    wait_any_ack(10, n, g);
    check("rdff_lat",  32'(n),       3);
    check("rdff_ack",  32'(ack_a),   32'b100);
    check("rdff_data", 32'(rdata_a), 1);
    idle(6);

    // Contention: three reads held, rotation 0,1,2,0 every 4 cycles.
    set_addr(0, 8'hFF); set_addr(1, 8'h35); set_addr(2, 8'h00);
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100; exp_ack[3] = 3'b001;
    exp_rd[0]  = 1'b1;   exp_rd[1]  = 1'b0;   exp_rd[2]  = 1'b0;   exp_rd[3]  = 1'b1;
    req = 3'b111; we = 3'b000;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(12, n, g);
      check($sformatf("cont%0d_spacing", k), 32'(n),       3);
      check($sformatf("cont%0d_ack", k),     32'(ack_a),   32'(exp_ack[k]));
      check($sformatf("cont%0d_gnt", k),     32'(g),       32'(exp_ack[k]));
      check($sformatf("cont%0d_data", k),    32'(rdata_a), 32'(exp_rd[k]));
      if (k == 3) req = 3'b000;
      tick();
    end
    idle(6);

    // Withdrawal: solver drops req after gnt, display pulses req for one cycle.
    req = 3'b010; we = 3'b000; set_addr(1, 8'hFF);
    tick();
    check("wd_gnt1", 32'(gnt_a), 32'b010);
    req = 3'b100;
    tick();
    req = 3'b000;
    check("wd_gnt_hold", 32'(gnt_a), 32'b010);
    tick();
    check("wd_ack",  32'(ack_a),   32'b010);
    check("wd_data", 32'(rdata_a), 1);
    tick();
    g = 3'b000;
    for (int i = 0; i < 5; i++) begin
      g |= gnt_a;
      tick();
    end
    check("wd_no_gnt2", 32'(g), 0);
    idle(2);

    // Lock burst: four loader writes while solver waits, then solver wins.
    ld_lock = 1'b1; req = 3'b011; we = 3'b011; wdata = 3'b011;
    set_addr(0, 8'h12); set_addr(1, 8'h34);
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(10, n, g);
      check($sformatf("lock%0d_ack", k), 32'(ack_a), 32'b001);
      check($sformatf("lock%0d_gnt", k), 32'(g),     32'b001);
      if (k == 3) begin
        ld_lock = 1'b0;
        req = 3'b010;
      end
      tick();
    end
    wait_any_ack(10, n, g);
    check("unlock_ack", 32'(ack_a), 32'b010);
    check("unlock_lat", 32'(n),     2);
    check("lock_mem12", 32'(mem_a[8'h12]), 1);
    check("lock_mem34", 32'(mem_a[8'h34]), 1);
    idle(10);

    // Reset in the middle of an RD_LAT=3 read on instance b.
    req = 3'b010; we = 3'b000; set_addr(1, 8'h35);
    tick();
    check("rr_b_en", 32'(mem_en_b), 1);
    tick();
    check("rr_b_wait_gnt", 32'(gnt_b), 32'b010);
    tick();
    #2;
    Rst_n = 1'b0;
    req = 3'b100; set_addr(2, 8'hA5);
    #1;
    check("rr_b_gnt0",  32'(gnt_b),      0);
    check("rr_b_busy0", 32'(busy_b),     0);
    check("rr_b_ack0",  32'(ack_b),      0);
    check("rr_b_addr0", 32'(mem_addr_b), 0);
    check("rr_b_rd0",   32'(rdata_b),    0);
    tick();
    check("rr_b_noack", 32'(ack_b), 0);
    tick();
    Rst_n = 1'b1;
    check("rr_b_idle", 32'(busy_b), 0);
    tick();
    check("rr_b_gnt2",  32'(gnt_b),      32'b100);
    check("rr_b_addr2", 32'(mem_addr_b), 32'hA5);
    n = 0;
    while (ack_b == 3'b000 && n < 10) begin
      tick();
      n++;
    end
    check("rr_b_lat",  32'(n),       4);
    check("rr_b_ack",  32'(ack_b),   32'b100);
    check("rr_b_data", 32'(rdata_b), 1);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
